// File: rtl/dsp_cmd_driver.sv
// -----------------------------------------------------------------------------
// dsp_cmd_driver
//
// Initiator-side front end for the DSP vector unit. The CPU loads eight A and
// eight B operand words, then issues a command. The block presents the
// operands and op code to the DSP, pulses dsp_start once, waits for dsp_done
// (bounded by TIMEOUT cycles), captures the eight result words and raises an
// interrupt.
//
// Ports
//   clk, rst               clock (posedge) / asynchronous active-low reset
//   wr_en/wr_addr/wr_data  operand write: addr 0-7 -> A[addr], 8-15 -> B[addr-8]
//   cmd_valid/cmd_op       command request and op (00 add, 01 mul, 11 sub, 10 FIR)
//   cmd_ready              high only while idle
//   rd_addr/rd_data        combinational read-back of captured results
//   busy                   high whenever not idle
//   res_valid              results captured; cleared by the next accepted command
//   err                    timeout flag; sticky until the next accepted command
//   irq                    one-cycle pulse on completion or timeout
//   dsp_start              one-cycle start pulse to the DSP
//   dsp_operation          op code held for the whole run
//   dsp_A/dsp_B            operand registers
//   dsp_result/dsp_done    DSP result words and one-cycle completion pulse
// -----------------------------------------------------------------------------
module dsp_cmd_driver #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [3:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic        cmd_valid,
   input  logic [1:0]  cmd_op,
   output logic        cmd_ready,
   input  logic [2:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic        busy,
   output logic        res_valid,
   output logic        err,
   output logic        irq,
   output logic        dsp_start,
   output logic [1:0]  dsp_operation,
   output logic [31:0] dsp_A [8],
   output logic [31:0] dsp_B [8],
   input  logic [31:0] dsp_result [8],
   input  logic        dsp_done
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       op_q;
   logic             start_q;
   logic             res_valid_q;
   logic             err_q;
   logic             irq_q;
   logic [31:0]      a_q   [8];
   logic [31:0]      b_q   [8];
   logic [31:0]      res_q [8];

   // Each state's actions are registered on the edge that leaves the state,
   // so dsp_start is high in the first WAIT cycle (two cycles after the
   // accept edge) and res_valid/irq rise one cycle after dsp_done is sampled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         start_q     <= 1'b0;
         res_valid_q <= 1'b0;
         err_q       <= 1'b0;
         irq_q       <= 1'b0;
         // NOTE: the operand and result arrays are small register files whose
         // reset value is visible on the ports, so they are reset explicitly
         // rather than left to power-up contents.
         for (int i = 0; i < 8; i++) begin
            a_q[i]   <= '0;
            b_q[i]   <= '0;
            res_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments throughout; the pulse defaults below
         // are overridden later in the same block by the state that fires them.
         start_q <= 1'b0;
         irq_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               // A write in the same cycle as the command lands on the same
               // edge, so the issued command already sees the new word.
               if (wr_en) begin
                  if (wr_addr[3]) b_q[wr_addr[2:0]] <= wr_data;
                  else            a_q[wr_addr[2:0]] <= wr_data;
               end
               if (cmd_valid) begin
                  op_q        <= cmd_op;
                  res_valid_q <= 1'b0;
                  err_q       <= 1'b0;
                  state_q     <= SETUP;
               end
            end
            // One quiet cycle so the DSP sees a stable op code while idle.
            SETUP: state_q <= START;
            START: begin
               start_q <= 1'b1;
               cnt_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (dsp_done) begin
                  for (int i = 0; i < 8; i++) res_q[i] <= dsp_result[i];
                  state_q <= DONE;
               end else if (cnt_q == CNT_LAST) begin
                  err_q   <= 1'b1;
                  irq_q   <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               res_valid_q <= 1'b1;
               irq_q       <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready     = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign res_valid     = res_valid_q;
   assign err           = err_q;
   assign irq           = irq_q;
   assign dsp_start     = start_q;
   assign dsp_operation = op_q;
   assign dsp_A         = a_q;
   assign dsp_B         = b_q;
   // Read-back is live in every state; during a run it still shows the
   // previous command's results.
   assign rd_data       = res_q[rd_addr];

endmodule

// File: tb/tb_dsp_cmd_driver.sv
// -----------------------------------------------------------------------------
// tb_dsp_cmd_driver
//
// Directed bench for dsp_cmd_driver. Instance dut uses the default TIMEOUT and
// talks to a behavioural DSP (add/mul/sub after 3 cycles, FIR stub returning
// 0xA0+i after 40 cycles). Instance dut_t uses TIMEOUT=16 and has its done
// and result inputs driven directly from the stimulus.
// -----------------------------------------------------------------------------
module tb_dsp_cmd_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic        cmd_valid;
   logic [1:0]  cmd_op;
   logic [2:0]  rd_addr;

   logic        cmd_ready, busy, res_valid, err, irq, dsp_start, dsp_done;
   logic [1:0]  dsp_operation;
   logic [31:0] rd_data;
   logic [31:0] dsp_A [8];
   logic [31:0] dsp_B [8];
   logic [31:0] dsp_result [8];

   logic        t_cmd_valid, t_dsp_done;
   logic        t_cmd_ready, t_busy, t_res_valid, t_err, t_irq, t_dsp_start;
   logic [1:0]  t_dsp_operation;
   logic [31:0] t_rd_data;
   logic [31:0] t_A [8];
   logic [31:0] t_B [8];
   logic [31:0] t_result [8];

   int vectors = 0;
   int miscompares = 0;
   int start_count = 0;

   always #5 clk = ~clk;

   dsp_cmd_driver dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .res_valid(res_valid),
      .err(err), .irq(irq), .dsp_start(dsp_start), .dsp_operation(dsp_operation),
      .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_result(dsp_result), .dsp_done(dsp_done)
   );

   dsp_cmd_driver #(.TIMEOUT(16)) dut_t (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cmd_valid(t_cmd_valid), .cmd_op(cmd_op), .cmd_ready(t_cmd_ready),
      .rd_addr(rd_addr), .rd_data(t_rd_data), .busy(t_busy), .res_valid(t_res_valid),
      .err(t_err), .irq(t_irq), .dsp_start(t_dsp_start), .dsp_operation(t_dsp_operation),
      .dsp_A(t_A), .dsp_B(t_B), .dsp_result(t_result), .dsp_done(t_dsp_done)
   );

   // Behavioural DSP on the falling edge, so everything it drives is stable
   // well before the DUT samples it.
   int          countdown;
   logic [31:0] pend [8];

   always @(negedge clk) begin
      if (!rst) begin
         countdown <= 0;
         dsp_done  <= 1'b0;
      end else begin
         dsp_done <= 1'b0;
         if (dsp_start) begin
            start_count <= start_count + 1;
            countdown   <= (dsp_operation == 2'b10) ? 40 : 3;
            for (int i = 0; i < 8; i++) begin
               case (dsp_operation)
                  2'b00:   pend[i] <= dsp_A[i] + dsp_B[i];
                  2'b01:   pend[i] <= dsp_A[i] * dsp_B[i];
                  2'b11:   pend[i] <= dsp_A[i] - dsp_B[i];
                  default: pend[i] <= 32'hA0 + 32'(i);
               endcase
            end
         end else if (countdown == 1) begin
            countdown <= 0;
            dsp_done  <= 1'b1;
            for (int i = 0; i < 8; i++) dsp_result[i] <= pend[i];
         end else if (countdown > 1) begin
            countdown <= countdown - 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic issue(input logic [1:0] op);
      cmd_op = op; cmd_valid = 1'b1;
      tick(1);
      cmd_valid = 1'b0;
   endtask

   // Poll until the DSP's done pulse is visible (bounded), then check the
   // one-cycle res_valid latency and the single-cycle irq.
   task automatic await_done(input string tag);
      int n;
      n = 0;
      while (dsp_done !== 1'b1 && n < 100) begin
         tick(1);
         n++;
      end
      check1({tag, " done_seen"}, dsp_done, 1'b1);
      check1({tag, " res_valid_pre"}, res_valid, 1'b0);
      tick(1);
      check1({tag, " res_valid"}, res_valid, 1'b1);
      check1({tag, " irq"}, irq, 1'b1);
      tick(1);
      check1({tag, " irq_drop"}, irq, 1'b0);
      check1({tag, " idle"}, busy, 1'b0);
   endtask

   task automatic check_results(input string tag, input logic [31:0] base, input logic [31:0] step);
      for (int i = 0; i < 8; i++) begin
         rd_addr = 3'(i);
         #1;
         check($sformatf("%s rd[%0d]", tag, i), rd_data, base + step * 32'(i));
      end
   endtask

   initial begin
      int s0;
      rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      cmd_valid = 1'b0; cmd_op = '0; rd_addr = '0;
      t_cmd_valid = 1'b0; t_dsp_done = 1'b0;
      for (int i = 0; i < 8; i++) t_result[i] = '0;
      tick(2);

      // Reset state
      check1("rst cmd_ready", cmd_ready, 1'b1);
      check1("rst busy", busy, 1'b0);
      check1("rst res_valid", res_valid, 1'b0);
      check1("rst err", err, 1'b0);
      check1("rst irq", irq, 1'b0);
      check1("rst dsp_start", dsp_start, 1'b0);
      check("rst dsp_operation", 32'(dsp_operation), 32'd0);
      check("rst rd_data", rd_data, 32'd0);
      rst = 1'b1;
      tick(1);

      // 1: add, A[i]=i+1, B[i]=10 -> i+11; start latency 2 cycles
      for (int i = 0; i < 8; i++) begin
         wr(4'(i), 32'(i + 1));
         wr(4'(8 + i), 32'd10);
      end
      check("t1 dsp_B[7]", dsp_B[7], 32'd10);
      s0 = start_count;
      issue(2'b00);
      check1("t1 busy", busy, 1'b1);
      check1("t1 cmd_ready", cmd_ready, 1'b0);
      check1("t1 start_c0", dsp_start, 1'b0);
      tick(1);
      check1("t1 start_c1", dsp_start, 1'b0);
      tick(1);
      check1("t1 start_c2", dsp_start, 1'b1);
      tick(1);
      check1("t1 start_c3", dsp_start, 1'b0);
      await_done("t1");
      check("t1 starts", 32'(start_count - s0), 32'd1);
      check_results("t1", 32'd11, 32'd1);

      // 2a: mul, A[i]=i, B[i]=3 -> 3*i
      for (int i = 0; i < 8; i++) begin
         wr(4'(i), 32'(i));
         wr(4'(8 + i), 32'd3);
      end
      issue(2'b01);
      await_done("t2mul");
      check_results("t2mul", 32'd0, 32'd3);

      // 2b: sub, A[i]=100, B[i]=i -> 100-i
      for (int i = 0; i < 8; i++) begin
         wr(4'(i), 32'd100);
         wr(4'(8 + i), 32'(i));
      end
      issue(2'b11);
      await_done("t2sub");
      check_results("t2sub", 32'd100, 32'hFFFF_FFFF);

      // 3 + 5: FIR stub (40 cycles); writes and commands during WAIT ignored
      s0 = start_count;
      issue(2'b10);
      tick(3);
      check("t3 op_held_a", 32'(dsp_operation), 32'd2);
      check1("t5 busy", busy, 1'b1);
      wr(4'd3, 32'h0000_DEAD);
      check("t5 A3_kept", dsp_A[3], 32'd100);
      cmd_op = 2'b00; cmd_valid = 1'b1;
      tick(5);
      check1("t5 cmd_ready", cmd_ready, 1'b0);
      cmd_valid = 1'b0;
      check("t3 op_held_b", 32'(dsp_operation), 32'd2);
      check("t3 rd_prev", rd_data, 32'd100 - 32'(rd_addr));
      await_done("t3");
      check("t5 starts", 32'(start_count - s0), 32'd1);
      check("t5 A3_after", dsp_A[3], 32'd100);
      check_results("t3", 32'hA0, 32'd1);

      // 4: TIMEOUT=16 instance; first capture known results via a manual done
      for (int i = 0; i < 8; i++) t_result[i] = 32'h5000 + 32'(i);
      rd_addr = 3'd5;
      cmd_op = 2'b00; t_cmd_valid = 1'b1;
      tick(1);
      t_cmd_valid = 1'b0;
      tick(3);
      t_dsp_done = 1'b1;
      tick(1);
      t_dsp_done = 1'b0;
      tick(1);
      check1("t4 first res_valid", t_res_valid, 1'b1);
      check("t4 first rd", t_rd_data, 32'h5005);
      tick(1);
      for (int i = 0; i < 8; i++) t_result[i] = 32'hFFFF_0000 + 32'(i);
      t_cmd_valid = 1'b1;
      tick(1);
      t_cmd_valid = 1'b0;
      check1("t4 res_valid_clr", t_res_valid, 1'b0);
      tick(17);
      check1("t4 err_early", t_err, 1'b0);
      check1("t4 irq_early", t_irq, 1'b0);
      tick(1);
      check1("t4 err", t_err, 1'b1);
      check1("t4 irq", t_irq, 1'b1);
      check1("t4 res_valid", t_res_valid, 1'b0);
      check1("t4 cmd_ready", t_cmd_ready, 1'b1);
      check("t4 rd_kept", t_rd_data, 32'h5005);
      tick(1);
      check1("t4 irq_drop", t_irq, 1'b0);
      check1("t4 err_sticky", t_err, 1'b1);
      // done while idle is ignored
      t_dsp_done = 1'b1;
      tick(1);
      t_dsp_done = 1'b0;
      tick(1);
      check1("t4 idle_done res_valid", t_res_valid, 1'b0);
      check("t4 idle_done rd", t_rd_data, 32'h5005);
      check1("t4 idle_done busy", t_busy, 1'b0);
      // next command accepted, err cleared
      t_cmd_valid = 1'b1;
      tick(1);
      t_cmd_valid = 1'b0;
      check1("t4 reissue busy", t_busy, 1'b1);
      check1("t4 reissue err_clr", t_err, 1'b0);

      // 6: asynchronous reset in the middle of WAIT
      issue(2'b00);
      tick(3);
      check1("t6 in_wait", busy, 1'b1);
      #2 rst = 1'b0;
      #1;
      check1("t6 busy", busy, 1'b0);
      check1("t6 cmd_ready", cmd_ready, 1'b1);
      check1("t6 dsp_start", dsp_start, 1'b0);
      check1("t6 res_valid", res_valid, 1'b0);
      check1("t6 err", err, 1'b0);
      check1("t6 irq", irq, 1'b0);
      check("t6 op", 32'(dsp_operation), 32'd0);
      check("t6 A0", dsp_A[0], 32'd0);
      check("t6 rd", rd_data, 32'd0);
      tick(2);
      rst = 1'b1;
      tick(1);
      for (int i = 0; i < 8; i++) begin
         wr(4'(i), 32'(2 * i));
         wr(4'(8 + i), 32'd7);
      end
      s0 = start_count;
      issue(2'b00);
      await_done("t6");
      check("t6 starts", 32'(start_count - s0), 32'd1);
      check_results("t6", 32'd7, 32'd2);

      // Same-cycle write and command: the command uses the new word
      wr_en = 1'b1; wr_addr = 4'd8; wr_data = 32'd50;
      cmd_op = 2'b00; cmd_valid = 1'b1;
      tick(1);
      wr_en = 1'b0; cmd_valid = 1'b0;
      await_done("same");
      rd_addr = 3'd0;
      #1;
      check("same rd0", rd_data, 32'd50);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
